// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Generic pipeline stage register (PC, PC+4, instruction, sideband) with a
// full valid/ready handshake backed by a two-entry skid buffer.  in_ready is
// derived only from the state register, so it never combinationally depends
// on out_ready or suspend.  The stage also supports a hazard suspend, which
// blocks output transfer, and a branch-redirect flush, which kills all held
// entries.
//
// Optional feature: define PIPE_STAGE_PERF_EN to build the saturating
// stall-cycle and flush counters.  Without the macro both perf ports are
// tied to zero and no counter logic exists.
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned INST_W     = 32,
  parameter int unsigned SIDE_W     = 8,
  parameter logic [31:0] RESET_INST = 32'h00000013
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic              flush,
  input  logic              suspend,
  input  logic              valid_in,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [PC_W-1:0]   pc4_in,
  input  logic [INST_W-1:0] inst_in,
  input  logic [SIDE_W-1:0] side_in,
  output logic              valid_out,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   pc4_out,
  output logic [INST_W-1:0] inst_out,
  output logic [SIDE_W-1:0] side_out,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  // RESET_INST sized to the instruction field (truncated or zero-extended).
  localparam logic [INST_W-1:0] ResetInst = INST_W'(RESET_INST);

  // EMPTY: nothing held, FULL: main entry held, SKID: main and skid held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Main entry drives the outputs; skid entry holds one overflow beat.
  logic [PC_W-1:0]   mainPc_q,   skidPc_q;
  logic [PC_W-1:0]   mainPc4_q,  skidPc4_q;
  logic [INST_W-1:0] mainInst_q, skidInst_q;
  logic [SIDE_W-1:0] mainSide_q, skidSide_q;

  logic fireIn;
  logic fireOut;
  logic loadMainFromIn;
  logic loadMainFromSkid;
  logic loadSkid;

  // Handshake terms; suspend behaves exactly like a deasserted out_ready.
  assign in_ready  = (state_q != SKID);
  assign valid_out = (state_q != EMPTY);
  assign fireIn    = valid_in & in_ready;
  assign fireOut   = valid_out & out_ready & ~suspend;

  assign pc_out   = mainPc_q;
  assign pc4_out  = mainPc4_q;
  assign inst_out = mainInst_q;
  assign side_out = mainSide_q;

  // Next-state and data-load decode; flush overrides everything and also
  // suppresses data loads so the registers keep their previous contents.
  always_comb begin
    state_d          = state_q;
    loadMainFromIn   = 1'b0;
    loadMainFromSkid = 1'b0;
    loadSkid         = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (fireIn) begin
          state_d        = FULL;
          loadMainFromIn = 1'b1;
        end
      end
      FULL: begin
        if (fireIn && fireOut) begin
          state_d        = FULL;
          loadMainFromIn = 1'b1;
        end else if (fireIn) begin
          state_d  = SKID;
          loadSkid = 1'b1;
        end else if (fireOut) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (fireOut) begin
          state_d          = FULL;
          loadMainFromSkid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (flush) begin
      state_d          = EMPTY;
      loadMainFromIn   = 1'b0;
      loadMainFromSkid = 1'b0;
      loadSkid         = 1'b0;
    end
  end

  // State register, cleared asynchronously to EMPTY.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main entry: loads a fresh beat or drains the skid entry forward.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      mainPc_q   <= '0;
      mainPc4_q  <= '0;
      mainInst_q <= ResetInst;
      mainSide_q <= '0;
    end else if (loadMainFromIn) begin
      mainPc_q   <= pc_in;
      mainPc4_q  <= pc4_in;
      mainInst_q <= inst_in;
      mainSide_q <= side_in;
    end else if (loadMainFromSkid) begin
      mainPc_q   <= skidPc_q;
      mainPc4_q  <= skidPc4_q;
      mainInst_q <= skidInst_q;
      mainSide_q <= skidSide_q;
    end
  end

  // Skid entry: captures the beat accepted while the output is blocked.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      skidPc_q   <= '0;
      skidPc4_q  <= '0;
      skidInst_q <= ResetInst;
      skidSide_q <= '0;
    end else if (loadSkid) begin
      skidPc_q   <= pc_in;
      skidPc4_q  <= pc4_in;
      skidInst_q <= inst_in;
      skidSide_q <= side_in;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stallCnt_q, stallCnt_d;
  logic [31:0] flushCnt_q, flushCnt_d;

  // Saturating counters: a stall is a held beat that did not leave this
  // cycle (flush cycles excluded); a flush counts only if it killed data.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (valid_out && !fireOut && !flush && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_d = stallCnt_q + 32'd1;
    end
    if (flush && valid_out && (flushCnt_q != 32'hFFFF_FFFF)) begin
      flushCnt_d = flushCnt_q + 32'd1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign perf_stall_cnt = stallCnt_q;
  assign perf_flush_cnt = flushCnt_q;
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule
